// File: rtl/patp_control_unit.sv
// -----------------------------------------------------------------------------
// patp_control_unit
//
// Self-sequencing control unit for the PATP core. An internal fetch/execute
// state machine (IDLE, F1..F4, E1, E2) latches the opcode at the end of fetch
// and drives every datapath strobe directly. A run/step controller decides
// whether the machine continues at each instruction boundary. A wrapping
// counter tracks retired instructions.
//
// Optional feature macro: PATP_MEM_WAIT_EN
//   defined   : F2, load E2 and store E2 stall while mem_ready=0, with their
//               strobes held asserted.
//   undefined : mem_ready is ignored and every state lasts one cycle.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   opcode            IR opcode field, valid from F3 onward
//   z                 zero flag, used only in buz E1
//   run               level: 1 = free-run, 0 = halt at instruction boundary
//   step              pulse: run one instruction while halted
//   mem_ready         memory completion (PATP_MEM_WAIT_EN only)
//   oe_*              bus output enables
//   func              ALU function: 00 zero, 01 inc, 10 add, 11 dec
//   read, write       memory strobes
//   we_*              register write enables
//   halted            controller is in IDLE
//   instr_done        last cycle of the current instruction
//   illegal           E1 of an illegal opcode (>= 8)
//   instr_count       retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module patp_control_unit #(
  parameter int OPCODE_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                z,
  input  logic                run,
  input  logic                step,
  input  logic                mem_ready,
  output logic                oe_ms,
  output logic                oe_ir,
  output logic                oe_pc,
  output logic                oe_d0,
  output logic                oe_alureg,
  output logic [1:0]          func,
  output logic                read,
  output logic                write,
  output logic                we_mar,
  output logic                we_ir,
  output logic                we_pc,
  output logic                we_d0,
  output logic                we_alureg,
  output logic                halted,
  output logic                instr_done,
  output logic                illegal,
  output logic [CNT_W-1:0]    instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_F1, S_F2, S_F3, S_F4, S_E1, S_E2
  } state_t;

  localparam logic [1:0] FUNC_ZERO = 2'b00;
  localparam logic [1:0] FUNC_INC  = 2'b01;
  localparam logic [1:0] FUNC_ADD  = 2'b10;
  localparam logic [1:0] FUNC_DEC  = 2'b11;

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic                step_q, step_d;
  logic                illegal_op;
  logic                mem_ok;
  logic                last;
  logic [2:0]          op_lo;

  assign op_lo = op_q[2:0];

  // Any set bit above the low three makes the code >= 8.
  generate
    if (OPCODE_W > 3) begin : g_wide_op
      assign illegal_op = |op_q[OPCODE_W-1:3];
    end else begin : g_narrow_op
      assign illegal_op = 1'b0;
    end
  endgenerate

`ifdef PATP_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    oe_ms      = 1'b0;
    oe_ir      = 1'b0;
    oe_pc      = 1'b0;
    oe_d0      = 1'b0;
    oe_alureg  = 1'b0;
    func       = FUNC_ZERO;
    read       = 1'b0;
    write      = 1'b0;
    we_mar     = 1'b0;
    we_ir      = 1'b0;
    we_pc      = 1'b0;
    we_d0      = 1'b0;
    we_alureg  = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    last       = 1'b0;
    state_d    = state_q;
    step_d     = step_q;

    unique case (state_q)
      S_IDLE: begin
        halted = 1'b1;
        if (run || step) begin
          state_d = S_F1;
          // A step while running is meaningless; only arm the one-shot when halted.
          step_d  = step & ~run;
        end
      end
      S_F1: begin
        oe_pc   = 1'b1;
        we_mar  = 1'b1;
        state_d = S_F2;
      end
      S_F2: begin
        read  = 1'b1;
        oe_ms = 1'b1;
        we_ir = 1'b1;
        if (mem_ok) state_d = S_F3;
      end
      S_F3: begin
        oe_pc     = 1'b1;
        func      = FUNC_INC;
        we_alureg = 1'b1;
        state_d   = S_F4;
      end
      S_F4: begin
        oe_alureg = 1'b1;
        we_pc     = 1'b1;
        state_d   = S_E1;
      end
      S_E1: begin
        state_d = S_E2;
        if (illegal_op) begin
          illegal = 1'b1;
          last    = 1'b1;
        end else begin
          unique case (op_lo)
            3'd0: begin func = FUNC_ZERO; we_alureg = 1'b1; end
            3'd1: begin func = FUNC_INC;  we_alureg = 1'b1; oe_d0 = 1'b1; end
            3'd2: begin func = FUNC_ADD;  we_alureg = 1'b1; oe_ir = 1'b1; end
            3'd3: begin func = FUNC_DEC;  we_alureg = 1'b1; oe_d0 = 1'b1; end
            3'd4: begin oe_ir = 1'b1; we_pc = 1'b1; last = 1'b1; end
            3'd5: begin
              oe_ir = z;
              we_pc = z;
              last  = 1'b1;
            end
            default: begin oe_ir = 1'b1; we_mar = 1'b1; end  // load, store
          endcase
        end
      end
      S_E2: begin
        unique case (op_lo)
          3'd6: begin read = 1'b1; oe_ms = 1'b1; we_d0 = 1'b1; last = mem_ok; end
          3'd7: begin oe_d0 = 1'b1; write = 1'b1; last = mem_ok; end
          default: begin oe_alureg = 1'b1; we_d0 = 1'b1; last = 1'b1; end
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    // Instruction boundary: continue only when free-running and not stepping.
    if (last) begin
      state_d = (run && !step_q) ? S_F1 : S_IDLE;
      step_d  = 1'b0;
    end
  end

  assign instr_done = last;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      step_q      <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (state_q == S_F4) op_q <= opcode;
      if (last) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_patp_control_unit.sv
// -----------------------------------------------------------------------------
// tb_patp_control_unit
//
// Directed bench for patp_control_unit, built with OPCODE_W=4 and CNT_W=4 so
// illegal opcodes and counter wrap are reachable. Inputs change on the falling
// edge; outputs are sampled on the falling edge before inputs are updated.
// Observed vector: {oe_ms, oe_ir, oe_pc, oe_d0, oe_alureg, func[1:0], read,
// write, we_mar, we_ir, we_pc, we_d0, we_alureg, instr_done, illegal, halted}.
// -----------------------------------------------------------------------------
module tb_patp_control_unit;

  localparam int OPCODE_W = 4;
  localparam int CNT_W    = 4;

  localparam logic [13:0] S_OE_MS  = 14'h2000;
  localparam logic [13:0] S_OE_IR  = 14'h1000;
  localparam logic [13:0] S_OE_PC  = 14'h0800;
  localparam logic [13:0] S_OE_D0  = 14'h0400;
  localparam logic [13:0] S_OE_ALU = 14'h0200;
  localparam logic [13:0] S_F_ADD  = 14'h0100;
  localparam logic [13:0] S_F_INC  = 14'h0080;
  localparam logic [13:0] S_F_DEC  = 14'h0180;
  localparam logic [13:0] S_RD     = 14'h0040;
  localparam logic [13:0] S_WR     = 14'h0020;
  localparam logic [13:0] S_WE_MAR = 14'h0010;
  localparam logic [13:0] S_WE_IR  = 14'h0008;
  localparam logic [13:0] S_WE_PC  = 14'h0004;
  localparam logic [13:0] S_WE_D0  = 14'h0002;
  localparam logic [13:0] S_WE_ALU = 14'h0001;

  localparam logic [16:0] X_IDLE = 17'b1;
  localparam logic [16:0] X_F1   = {S_OE_PC | S_WE_MAR, 3'b000};
  localparam logic [16:0] X_F2   = {S_RD | S_OE_MS | S_WE_IR, 3'b000};
  localparam logic [16:0] X_F3   = {S_OE_PC | S_F_INC | S_WE_ALU, 3'b000};
  localparam logic [16:0] X_F4   = {S_OE_ALU | S_WE_PC, 3'b000};

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [OPCODE_W-1:0] opcode = '0;
  logic                z = 1'b0;
  logic                run = 1'b0;
  logic                step = 1'b0;
  logic                mem_ready = 1'b0;
  logic                oe_ms, oe_ir, oe_pc, oe_d0, oe_alureg;
  logic [1:0]          func;
  logic                read, write;
  logic                we_mar, we_ir, we_pc, we_d0, we_alureg;
  logic                halted, instr_done, illegal;
  logic [CNT_W-1:0]    instr_count;

  int unsigned         checks = 0;
  int unsigned         failures = 0;
  logic [CNT_W-1:0]    exp_cnt = '0;

  always #5 clk = ~clk;

  patp_control_unit #(.OPCODE_W(OPCODE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .z(z), .run(run), .step(step),
    .mem_ready(mem_ready), .oe_ms(oe_ms), .oe_ir(oe_ir), .oe_pc(oe_pc),
    .oe_d0(oe_d0), .oe_alureg(oe_alureg), .func(func), .read(read),
    .write(write), .we_mar(we_mar), .we_ir(we_ir), .we_pc(we_pc),
    .we_d0(we_d0), .we_alureg(we_alureg), .halted(halted),
    .instr_done(instr_done), .illegal(illegal), .instr_count(instr_count)
  );

  function automatic logic [16:0] obs();
    return {oe_ms, oe_ir, oe_pc, oe_d0, oe_alureg, func, read, write,
            we_mar, we_ir, we_pc, we_d0, we_alureg, instr_done, illegal, halted};
  endfunction

  function automatic logic [16:0] mk(input logic [13:0] s, input logic d, input logic il);
    return {s, d, il, 1'b0};
  endfunction

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? '0 : c + 1'b1;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== X_IDLE) begin
      failures++; $display("FAIL reset_outputs: got %h want %h", obs(), X_IDLE);
    end
    checks++;
    if (instr_count !== '0) begin
      failures++; $display("FAIL reset_count: got %0d want 0", instr_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== X_IDLE) begin
      failures++; $display("FAIL reset_idle_hold: got %h want %h", obs(), X_IDLE);
    end
  endtask

  // inc1 under run, then jmp with run dropped mid-instruction.
  task automatic test_inc1_jmp();
    logic [16:0] exp [13];
    exp = '{X_F1, X_F2, X_F3, X_F4,
            mk(S_F_INC | S_WE_ALU | S_OE_D0, 1'b0, 1'b0),
            mk(S_OE_ALU | S_WE_D0, 1'b1, 1'b0),
            X_F1, X_F2, X_F3, X_F4,
            mk(S_OE_IR | S_WE_PC, 1'b1, 1'b0),
            X_IDLE, X_IDLE};
    run = 1'b1; opcode = 4'd1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp[i]) begin
        failures++; $display("FAIL inc1_jmp[%0d]: got %h want %h", i, obs(), exp[i]);
      end
      if (i == 6 || i == 11) begin
        exp_cnt = cnt_next(exp_cnt);
        checks++;
        if (instr_count !== exp_cnt) begin
          failures++; $display("FAIL inc1_jmp_count[%0d]: got %0d want %0d", i, instr_count, exp_cnt);
        end
      end
      if (i == 6) begin run = 1'b0; opcode = 4'd4; end
    end
  endtask

  // buz not taken, then taken, back to back.
  task automatic test_buz();
    logic [16:0] exp [11];
    exp = '{X_F1, X_F2, X_F3, X_F4, mk(14'h0, 1'b1, 1'b0),
            X_F1, X_F2, X_F3, X_F4, mk(S_OE_IR | S_WE_PC, 1'b1, 1'b0),
            X_IDLE};
    run = 1'b1; opcode = 4'd5; z = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp[i]) begin
        failures++; $display("FAIL buz[%0d]: got %h want %h", i, obs(), exp[i]);
      end
      if (i == 5 || i == 10) begin
        exp_cnt = cnt_next(exp_cnt);
        checks++;
        if (instr_count !== exp_cnt) begin
          failures++; $display("FAIL buz_count[%0d]: got %0d want %0d", i, instr_count, exp_cnt);
        end
      end
      if (i == 4) z = 1'b1;
      if (i == 9) run = 1'b0;
    end
    z = 1'b0;
  endtask

  // Two single steps of store while halted.
  task automatic test_step_store();
    logic [16:0] exp [8];
    exp = '{X_F1, X_F2, X_F3, X_F4,
            mk(S_OE_IR | S_WE_MAR, 1'b0, 1'b0),
            mk(S_OE_D0 | S_WR, 1'b1, 1'b0),
            X_IDLE, X_IDLE};
    opcode = 4'd7;
    for (int r = 0; r < 2; r++) begin
      step = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        checks++;
        if (obs() !== exp[i]) begin
          failures++; $display("FAIL step_store%0d[%0d]: got %h want %h", r, i, obs(), exp[i]);
        end
        if (i == 0) step = 1'b0;
        if (i == 6) begin
          exp_cnt = cnt_next(exp_cnt);
          checks++;
          if (instr_count !== exp_cnt) begin
            failures++; $display("FAIL step_store_count%0d: got %0d want %0d", r, instr_count, exp_cnt);
          end
        end
      end
    end
  endtask

  // Illegal code 9, then the following add fetch proceeds normally.
  task automatic test_illegal_add();
    logic [16:0] exp [12];
    exp = '{X_F1, X_F2, X_F3, X_F4, mk(14'h0, 1'b1, 1'b1),
            X_F1, X_F2, X_F3, X_F4,
            mk(S_F_ADD | S_WE_ALU | S_OE_IR, 1'b0, 1'b0),
            mk(S_OE_ALU | S_WE_D0, 1'b1, 1'b0),
            X_IDLE};
    run = 1'b1; opcode = 4'd9;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp[i]) begin
        failures++; $display("FAIL illegal_add[%0d]: got %h want %h", i, obs(), exp[i]);
      end
      if (i == 5 || i == 11) begin
        exp_cnt = cnt_next(exp_cnt);
        checks++;
        if (instr_count !== exp_cnt) begin
          failures++; $display("FAIL illegal_add_count[%0d]: got %0d want %0d", i, instr_count, exp_cnt);
        end
      end
      if (i == 5) begin run = 1'b0; opcode = 4'd2; end
    end
  endtask

  // load: with the wait feature, mem_ready low 3 cycles in F2 and in E2.
  task automatic test_load();
    logic [16:0] exp [13];
    logic        mr [13];
    int          n;
    logic [16:0] x_e1, x_e2;
    x_e1 = mk(S_OE_IR | S_WE_MAR, 1'b0, 1'b0);
    x_e2 = mk(S_RD | S_OE_MS | S_WE_D0, 1'b0, 1'b0);
    for (int k = 0; k < 13; k++) begin exp[k] = X_IDLE; mr[k] = 1'b0; end
`ifdef PATP_MEM_WAIT_EN
    n = 12;
    exp[0] = X_F1;
    for (int k = 1; k < 5; k++) exp[k] = X_F2;
    exp[5] = X_F3; exp[6] = X_F4; exp[7] = x_e1;
    for (int k = 8; k < 11; k++) exp[k] = x_e2;
    exp[11] = mk(S_RD | S_OE_MS | S_WE_D0, 1'b1, 1'b0);
    mr[4] = 1'b1; mr[11] = 1'b1;
`else
    n = 6;
    exp[0] = X_F1; exp[1] = X_F2; exp[2] = X_F3; exp[3] = X_F4;
    exp[4] = x_e1;
    exp[5] = mk(S_RD | S_OE_MS | S_WE_D0, 1'b1, 1'b0);
`endif
    run = 1'b1; opcode = 4'd6; mem_ready = mr[0];
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp[i]) begin
        failures++; $display("FAIL load[%0d]: got %h want %h", i, obs(), exp[i]);
      end
      if (i == 0) run = 1'b0;
      if (i + 1 < 13) mem_ready = mr[i+1];
    end
    exp_cnt = cnt_next(exp_cnt);
    checks++;
    if (instr_count !== exp_cnt) begin
      failures++; $display("FAIL load_count: got %0d want %0d", instr_count, exp_cnt);
    end
    mem_ready = 1'b0;
  endtask

  // dec1 back to back until the 4-bit counter wraps to 0.
  task automatic test_wrap();
    int nins;
    logic [16:0] x_e1, x_e2;
    x_e1 = mk(S_F_DEC | S_WE_ALU | S_OE_D0, 1'b0, 1'b0);
    x_e2 = mk(S_OE_ALU | S_WE_D0, 1'b1, 1'b0);
    nins = 16 - int'(exp_cnt);
    run = 1'b1; opcode = 4'd3;
    for (int k = 0; k < nins; k++) begin
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        if (c == 1) begin
          checks++;
          if (instr_count !== exp_cnt) begin
            failures++; $display("FAIL wrap_count[%0d]: got %0d want %0d", k, instr_count, exp_cnt);
          end
          if (k == nins - 1) run = 1'b0;
        end
        if (c == 5) begin
          checks++;
          if (obs() !== x_e1) begin
            failures++; $display("FAIL wrap_e1[%0d]: got %h want %h", k, obs(), x_e1);
          end
        end
        if (c == 6) begin
          checks++;
          if (obs() !== x_e2) begin
            failures++; $display("FAIL wrap_e2[%0d]: got %h want %h", k, obs(), x_e2);
          end
        end
      end
      exp_cnt = cnt_next(exp_cnt);
    end
    @(negedge clk);
    checks++;
    if (instr_count !== '0 || obs() !== X_IDLE) begin
      failures++; $display("FAIL wrap_final: got cnt=%0d obs=%h want cnt=0 obs=%h", instr_count, obs(), X_IDLE);
    end
  endtask

  // Asynchronous reset asserted in the middle of E1.
  task automatic test_async_reset();
    logic [16:0] x_e1;
    x_e1 = mk(S_WE_ALU, 1'b0, 1'b0);
    run = 1'b1; opcode = 4'd0;
    repeat (5) @(negedge clk);
    checks++;
    if (obs() !== x_e1) begin
      failures++; $display("FAIL areset_e1: got %h want %h", obs(), x_e1);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    checks++;
    if (obs() !== X_IDLE || instr_count !== exp_cnt) begin
      failures++; $display("FAIL areset_now: got obs=%h cnt=%0d want obs=%h cnt=0", obs(), instr_count, X_IDLE);
    end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== X_IDLE || instr_count !== exp_cnt) begin
      failures++; $display("FAIL areset_after: got obs=%h cnt=%0d want obs=%h cnt=0", obs(), instr_count, X_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_inc1_jmp();
    test_buz();
    test_step_store();
    test_illegal_add();
    test_load();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/patp_control_unit.md
# patp_control_unit

Self-sequencing control unit for the PATP core: replaces the one-hot instruction decode driven by externally generated phases t1..t5 with an internal fetch/execute state machine, an opcode latch, a run/step/halt controller, an optional memory-wait handshake and a retired-instruction counter. It sits between the instruction register and the datapath and drives every datapath strobe directly.

## Interface
- OPCODE_W, 3: opcode field width, ≥3. Codes ≥8 are illegal.
- CNT_W, 16: retired-instruction counter width.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPCODE_W  opcode field of IR, valid from F3 onward
- z  in  1  zero flag from D0/ALU
- run  in  1  level: 1 = free-run, 0 = halt at next instruction boundary
- step  in  1  single-cycle pulse: run one instruction while halted
- mem_ready  in  1  memory completion (used only under PATP_MEM_WAIT_EN)
- oe_ms, oe_ir, oe_pc, oe_d0, oe_alureg  out  1 each  bus output enables
- func  out  2  ALU function: 00 zero, 01 inc, 10 add, 11 dec
- read, write  out  1 each  memory strobes
- we_mar, we_ir, we_pc, we_d0, we_alureg  out  1 each  register write enables
- halted  out  1  controller in IDLE
- instr_done  out  1  high during last cycle of each instruction
- illegal  out  1  high during E1 of an illegal opcode
- instr_count  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, F1, F2, F3, F4, E1, E2. Registered state plus op_q (OPCODE_W); outputs decoded combinationally from state, op_q, z.
- IDLE: all strobes 0, halted=1. Exit to F1 when run=1 or step=1; step sets one-shot flag step_q.
- Fetch: F1 oe_pc+we_mar; F2 read+oe_ms+we_ir; F3 oe_pc, func=01, we_alureg; F4 oe_alureg+we_pc, op_q<=opcode on exit edge.
- Execute by op_q (0 clear, 1 inc1, 2 add, 3 dec1, 4 jmp, 5 buz, 6 load, 7 store):
- clear/inc1/add/dec1: E1 func=00/01/10/11, we_alureg, plus oe_d0 (inc1, dec1) or oe_ir (add); E2 oe_alureg+we_d0.
- jmp: E1 oe_ir+we_pc. buz: E1 oe_ir+we_pc only if z=1, else no strobes. Both single-cycle.
- load: E1 oe_ir+we_mar; E2 read+oe_ms+we_d0. store: E1 oe_ir+we_mar; E2 oe_d0+write.
- Illegal (op_q≥8): E1 only, no strobes, illegal=1.
- Last execute cycle: instr_done=1; on exit edge instr_count+=1 (wraps 2^CNT_W-1 → 0); next state F1 if run=1 and step_q=0, else IDLE, clearing step_q.
- step with run=1 ignored. run falling mid-instruction: instruction completes, then IDLE. func=00 whenever not specified.

## Timing
- Reset: state=IDLE, op_q=0, step_q=0, instr_count=0; all strobes and func 0, instr_done=0, illegal=0, halted=1. Reset mid-instruction aborts immediately; no strobe survives the assertion.
- IDLE→F1 one edge after run/step sampled high.
- Latency, no waits: ALU ops, load, store 6 cycles (F1..E2); jmp, buz, illegal 5 cycles. Back-to-back under run=1, no idle cycle.
- z sampled combinationally in buz E1 only.

## Configuration
- PATP_MEM_WAIT_EN defined: F2, load E2, store E2 hold while mem_ready=0 with strobes held asserted; advance on the first edge with mem_ready=1; instr_done asserts only in the completing cycle.
- Undefined: mem_ready ignored; every state lasts exactly one cycle.

## Test plan
- Reset then run=1, opcode=1 (inc1): F1..E2 strobe sequence exact; instr_done in cycle 6; instr_count=1; F1 next cycle.
- buz with z=0 then z=1: E1 no strobes, then oe_ir+we_pc; each 5 cycles.
- run=0, step pulse, opcode=7 (store): one instruction (E2 oe_d0+write), return to IDLE, halted=1, instr_count=1; second step repeats.
- OPCODE_W=4, opcode=9: illegal=1 in E1, no strobes, instr_count increments, next fetch proceeds.
- PATP_MEM_WAIT_EN, load, mem_ready low 3 cycles in F2 and E2: strobes held, instruction takes 12 cycles.
- CNT_W=4, 16 instructions retire: instr_count wraps 15→0; rst_n low in E1 forces all outputs to reset values asynchronously.
